// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter:
// FSM state encoding, parity mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam int NONE = 0;
  localparam int EVEN = 1;
  localparam int ODD  = 2;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// Handshake bundle between the upstream FIFO read side and the transmitter.
interface uart_tx_drain_if;
  logic       en;
  logic       empty;
  logic [7:0] q;
  logic       re;
  logic       tx;
  logic       busy;

  modport master (output en, empty, q, input re, tx, busy);
  modport slave  (input en, empty, q, output re, tx, busy);
endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: pulses bit_done on the last cycle of every bit
// and wraps to zero so each bit boundary restarts the count.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic r_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic bit_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == LAST);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (run) cnt_d = bit_done ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    // NOTE: non-blocking here so every flop samples pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls bytes from a FIFO read port (re/q/empty)
// and serialises them as start, 8 data bits LSB first, optional parity, stop.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       r_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       empty,
  input  logic [7:0] q,
  output logic       re,
  output logic       tx,
  output logic       busy
);
  if (CLKS_PER_BIT < 4) begin : g_bad_clks
    $error("uart_tx_drain: CLKS_PER_BIT must be 4 or more");
  end
  if (PARITY < NONE || PARITY > ODD) begin : g_bad_parity
    $error("uart_tx_drain: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_drain: STOP_BITS must be 1 or 2");
  end

  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       ready_q;
  logic       run, bit_done, fetch_ok;

  assign run      = state_q inside {START, DATA, PAR, STOP};
  assign fetch_ok = en && !empty;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .r_clk    (r_clk),
    .rst_n    (rst_n),
    .clear    (!run),
    .run      (run),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    unique case (state_q)
      // ready_q holds off the first fetch until one edge after reset release
      IDLE:  if (ready_q && fetch_ok) state_d = FETCH;
      FETCH: state_d = LATCH;
      LATCH: begin
        shreg_d = q;
        par_d   = parity_bit(q, PARITY);
        state_d = START;
      end
      START: if (bit_done) state_d = DATA;
      DATA: if (bit_done) begin
        shreg_d   = {1'b0, shreg_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = (PARITY != NONE) ? PAR : STOP;
      end
      PAR: if (bit_done) state_d = STOP;
      STOP: if (bit_done) begin
        if (stop_idx_q == LAST_STOP) begin
          stop_idx_d = 1'b0;
          state_d    = fetch_ok ? FETCH : IDLE;
        end else begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx trails the state by one cycle, giving a glitch-free registered line
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
      PAR:     tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= 1'b1;
    end
  end

  assign re   = (state_q == FETCH);
  assign busy = (state_q != IDLE);
  assign tx   = tx_q;
endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench: four transmitters (no parity, even, odd, two stop bits)
// each fed by a small FIFO model; tx waveforms compared against hand-built frames.
module tb_uart_tx_drain;
  logic       r_clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic [3:0] re_w, tx_w, busy_w;
  logic [7:0] mem [4][8];
  logic [7:0] q_r [4];
  int         wr_ptr [4];
  int         rd_ptr [4];
  int         re_cnt [4];
  int         total = 0;
  int         bad   = 0;

  always #5 r_clk = ~r_clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int PAR_G  = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int STOP_G = (g == 3) ? 2 : 1;

    uart_tx_drain_if bus ();

    assign bus.en    = en[g];
    assign bus.empty = (rd_ptr[g] == wr_ptr[g]);
    assign bus.q     = q_r[g];
    assign re_w[g]   = bus.re;
    assign tx_w[g]   = bus.tx;
    assign busy_w[g] = bus.busy;

    uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY(PAR_G), .STOP_BITS(STOP_G)) dut (
      .r_clk (r_clk),
      .rst_n (rst_n),
      .en    (bus.en),
      .empty (bus.empty),
      .q     (bus.q),
      .re    (bus.re),
      .tx    (bus.tx),
      .busy  (bus.busy)
    );
  end

  // Registered FIFO read port: data appears the cycle after re.
  always @(posedge r_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (re_w[i]) begin
        q_r[i]    <= mem[i][rd_ptr[i] % 8];
        rd_ptr[i] <= rd_ptr[i] + 1;
        re_cnt[i] <= re_cnt[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] b);
    mem[idx][wr_ptr[idx] % 8] = b;
    wr_ptr[idx] = wr_ptr[idx] + 1;
  endtask

  // Counts negedges until tx is low; returns 60 if it never falls.
  task automatic wait_tx_low(input int idx, output int n);
    n = 0;
    while (tx_w[idx] !== 1'b0 && n < 60) begin
      @(negedge r_clk);
      n++;
    end
  endtask

  // Called at the negedge of the first start-bit cycle; seq[k] is frame bit k.
  task automatic expect_bits(input int idx, input logic [11:0] seq, input int nbits,
                             input string tag);
    logic [3:0] s;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < 4; c++) begin
        s[c] = tx_w[idx];
        @(negedge r_clk);
      end
      check($sformatf("%s_bit%0d", tag, k), 32'(s), seq[k] ? 32'hF : 32'h0);
    end
  endtask

  initial begin
    int         n;
    int         base;
    logic       seen_re, seen_tx0, seen_busy;
    logic [7:0] txv, bsv;

    rst_n = 1'b0;
    en    = '0;
    repeat (3) @(negedge r_clk);
    check("rst_tx",   32'(tx_w),   32'hF);
    check("rst_re",   32'(re_w),   32'h0);
    check("rst_busy", 32'(busy_w), 32'h0);

    // 0x55 queued during reset: fetch on the second edge after release
    push(0, 8'h55);
    en[0] = 1'b1;
    rst_n = 1'b1;
    @(negedge r_clk);
    check("arm_re",   re_w[0],   0);
    check("arm_busy", busy_w[0], 0);
    @(negedge r_clk);
    check("first_fetch", re_w[0], 1);
    wait_tx_low(0, n);
    check("lat_after_rst", n, 3);
    expect_bits(0, 12'h2AA, 10, "f55");
    check("f55_busy", busy_w[0], 0);
    check("f55_idle", tx_w[0],   1);
    check("f55_re",   re_cnt[0], 1);

    // Empty FIFO with en high: nothing happens
    seen_re = 1'b0; seen_tx0 = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge r_clk);
      seen_re   |= re_w[0];
      seen_tx0  |= !tx_w[0];
      seen_busy |= busy_w[0];
    end
    check("idle_re",   seen_re,   0);
    check("idle_tx",   seen_tx0,  0);
    check("idle_busy", seen_busy, 0);

    // Back-to-back 0xA5, 0x3C: stop bit stretched by exactly 2 cycles
    base = re_cnt[0];
    push(0, 8'hA5);
    push(0, 8'h3C);
    wait_tx_low(0, n);
    check("lat_fetch", n, 4);
    expect_bits(0, 12'h34A, 10, "fa5");
    wait_tx_low(0, n);
    check("b2b_gap", n, 2);
    expect_bits(0, 12'h278, 10, "f3c");
    check("b2b_re",   re_cnt[0] - base, 2);
    check("b2b_busy", busy_w[0], 0);

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    push(1, 8'h07);
    en[1] = 1'b1;
    wait_tx_low(1, n);
    check("even_lat", n, 4);
    expect_bits(1, 12'h60E, 11, "even07");
    check("even_busy", busy_w[1], 0);
    push(2, 8'h07);
    en[2] = 1'b1;
    wait_tx_low(2, n);
    check("odd_lat", n, 4);
    expect_bits(2, 12'h40E, 11, "odd07");
    check("odd_busy", busy_w[2], 0);

    // Reset during data bit 3 of 0x00, then a queued 0xC3 goes out cleanly
    base = re_cnt[0];
    push(0, 8'h00);
    wait_tx_low(0, n);
    repeat (17) @(negedge r_clk);
    check("pre_rst_tx",   tx_w[0],   0);
    check("pre_rst_busy", busy_w[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx",   tx_w[0],   1);
    check("mid_rst_busy", busy_w[0], 0);
    check("mid_rst_re",   re_w[0],   0);
    push(0, 8'hC3);
    repeat (2) @(negedge r_clk);
    rst_n = 1'b1;
    wait_tx_low(0, n);
    check("lat_release", n, 5);
    expect_bits(0, 12'h386, 10, "fc3");
    check("rst_re", re_cnt[0] - base, 2);

    // Two stop bits; en dropped in data bit 0 with two more bytes queued
    base = re_cnt[3];
    push(3, 8'h81);
    push(3, 8'h42);
    push(3, 8'h99);
    en[3] = 1'b1;
    wait_tx_low(3, n);
    check("s2_lat", n, 4);
    fork
      begin
        repeat (4) @(negedge r_clk);
        en[3] = 1'b0;
      end
    join_none
    expect_bits(3, 12'h102, 9, "f81");
    for (int c = 0; c < 8; c++) begin
      txv[c] = tx_w[3];
      bsv[c] = busy_w[3];
      @(negedge r_clk);
    end
    check("s2_stop_tx",   txv, 8'hFF);
    check("s2_stop_busy", bsv, 8'h7F);
    seen_tx0 = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen_tx0  |= !tx_w[3];
      seen_busy |= busy_w[3];
      @(negedge r_clk);
    end
    check("s2_after_tx",   seen_tx0,  0);
    check("s2_after_busy", seen_busy, 0);
    check("s2_re",         re_cnt[3] - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
